// File: rtl/raster_defines_pkg.sv
// Shared raster-pipeline definitions: fixed-point widths, tile geometry and the
// per-tile record handed from the tile walker to the pixel stage.
package raster_defines;

   localparam int unsigned FX_TOTAL_BITS  = 16;
   localparam int unsigned FX_FRAC_BITS   = 4;
   localparam int unsigned ACC_W          = 2 * FX_TOTAL_BITS;
   localparam int unsigned TILE_WIDTH     = 8;
   localparam int unsigned LOG2_TW        = $clog2(TILE_WIDTH);
   localparam int unsigned SCREEN_TILES_X = 40;
   localparam int unsigned SCREEN_TILES_Y = 30;
   localparam int unsigned TW             = 6;
   localparam int unsigned NUM_EDGES      = 3;
   localparam int unsigned COLOR_W        = 4;

   typedef logic [ACC_W-1:0]         acc_t;
   typedef logic [FX_TOTAL_BITS-1:0] fx_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SEED,
      ST_TEST,
      ST_EMIT
   } walk_state_t;

   // Triangle set-up as latched at acceptance; values refer to pixel (0,0).
   typedef struct packed {
      logic [TW-1:0]               tx_min;
      logic [TW-1:0]               tx_max;
      logic [TW-1:0]               ty_min;
      logic [TW-1:0]               ty_max;
      acc_t [NUM_EDGES-1:0]        edg;
      fx_t  [NUM_EDGES-1:0]        edg_dx;
      fx_t  [NUM_EDGES-1:0]        edg_dy;
      acc_t                        z;
      fx_t                         dzdx;
      fx_t                         dzdy;
      logic [COLOR_W-1:0]          color;
   } tri_rec_t;

   // Per-tile output record; edge and z values refer to the tile's top-left pixel.
   typedef struct packed {
      logic [TW-1:0]               tile_x;
      logic [TW-1:0]               tile_y;
      fx_t                         abs_x;
      fx_t                         abs_y;
      acc_t [NUM_EDGES-1:0]        edg;
      fx_t  [NUM_EDGES-1:0]        edg_dx;
      fx_t  [NUM_EDGES-1:0]        edg_dy;
      acc_t                        z;
      fx_t                         dzdx;
      fx_t                         dzdy;
      logic [COLOR_W-1:0]          color;
      logic                        last;
   } tile_rec_t;

   function automatic acc_t sext(input fx_t v);
      return {{(ACC_W-FX_TOTAL_BITS){v[FX_TOTAL_BITS-1]}}, v};
   endfunction

   function automatic logic is_nonpos(input acc_t v);
      return v[ACC_W-1] || (v == '0);
   endfunction

endpackage

// File: rtl/tile_corner_test.sv
// Trivial-reject test for one tile: rejects when any edge is <= 0 at all four
// tile corners.
module tile_corner_test
   import raster_defines::*;
(
   input  logic [NUM_EDGES-1:0][ACC_W-1:0]         e_i,
   input  logic [NUM_EDGES-1:0][FX_TOTAL_BITS-1:0] dx_i,
   input  logic [NUM_EDGES-1:0][FX_TOTAL_BITS-1:0] dy_i,
   output logic                                    reject_c
);

   localparam acc_t SPAN = ACC_W'(TILE_WIDTH - 1);

   logic [NUM_EDGES-1:0] edge_out;

   for (genvar g = 0; g < NUM_EDGES; g++) begin : g_edge
      acc_t c00, c10, c01, c11;
      assign c00 = e_i[g];
      assign c10 = c00 + sext(dx_i[g]) * SPAN;
      assign c01 = c00 + sext(dy_i[g]) * SPAN;
      assign c11 = c10 + sext(dy_i[g]) * SPAN;
      assign edge_out[g] = is_nonpos(c00) && is_nonpos(c10)
                        && is_nonpos(c01) && is_nonpos(c11);
   end

   assign reject_c = |edge_out;

endmodule

// File: rtl/tile_walker.sv
// Walks the tile bounding box of one set-up triangle in raster order and emits
// a rebased record for every tile that survives the trivial-reject test.
module tile_walker
   import raster_defines::*;
(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     vld_in,
   output logic                     rdy_in,
   input  logic [TW-1:0]            in_tx_min,
   input  logic [TW-1:0]            in_tx_max,
   input  logic [TW-1:0]            in_ty_min,
   input  logic [TW-1:0]            in_ty_max,
   input  logic [ACC_W-1:0]         in_edge0,
   input  logic [ACC_W-1:0]         in_edge1,
   input  logic [ACC_W-1:0]         in_edge2,
   input  logic [FX_TOTAL_BITS-1:0] in_edge_dx0,
   input  logic [FX_TOTAL_BITS-1:0] in_edge_dx1,
   input  logic [FX_TOTAL_BITS-1:0] in_edge_dx2,
   input  logic [FX_TOTAL_BITS-1:0] in_edge_dy0,
   input  logic [FX_TOTAL_BITS-1:0] in_edge_dy1,
   input  logic [FX_TOTAL_BITS-1:0] in_edge_dy2,
   input  logic [ACC_W-1:0]         in_z,
   input  logic [FX_TOTAL_BITS-1:0] in_dzdx,
   input  logic [FX_TOTAL_BITS-1:0] in_dzdy,
   input  logic [COLOR_W-1:0]       in_color,
   input  logic                     rdy_out,
   output logic                     vld_out,
   output logic [TW-1:0]            out_tile_x,
   output logic [TW-1:0]            out_tile_y,
   output logic [FX_TOTAL_BITS-1:0] out_abs_x,
   output logic [FX_TOTAL_BITS-1:0] out_abs_y,
   output logic [ACC_W-1:0]         out_edge0,
   output logic [ACC_W-1:0]         out_edge1,
   output logic [ACC_W-1:0]         out_edge2,
   output logic [FX_TOTAL_BITS-1:0] out_edge_dx0,
   output logic [FX_TOTAL_BITS-1:0] out_edge_dx1,
   output logic [FX_TOTAL_BITS-1:0] out_edge_dx2,
   output logic [FX_TOTAL_BITS-1:0] out_edge_dy0,
   output logic [FX_TOTAL_BITS-1:0] out_edge_dy1,
   output logic [FX_TOTAL_BITS-1:0] out_edge_dy2,
   output logic [ACC_W-1:0]         out_z,
   output logic [FX_TOTAL_BITS-1:0] out_dzdx,
   output logic [FX_TOTAL_BITS-1:0] out_dzdy,
   output logic [COLOR_W-1:0]       out_color,
   output logic                     out_last
);

   localparam logic [TW-1:0] MAX_TX   = TW'(SCREEN_TILES_X - 1);
   localparam logic [TW-1:0] MAX_TY   = TW'(SCREEN_TILES_Y - 1);
   localparam int unsigned   ABS_SHIFT = LOG2_TW + FX_FRAC_BITS;

   walk_state_t          state_q, state_d;
   logic                 rdy_q, rdy_d;
   logic                 vld_q, vld_d;
   tri_rec_t             tri_q, tri_d;
   tile_rec_t            rec_q, rec_d;
   logic [TW-1:0]        tile_x_q, tile_x_d;
   logic [TW-1:0]        tile_y_q, tile_y_d;
   acc_t [NUM_EDGES-1:0] e_q, e_d;
   acc_t [NUM_EDGES-1:0] row_e_q, row_e_d;
   acc_t                 z_q, z_d;
   acc_t                 row_z_q, row_z_d;

   logic                 reject_c;
   logic                 last_tile;
   logic                 advance;

   tile_corner_test u_corner (
      .e_i      (e_q),
      .dx_i     (tri_q.edg_dx),
      .dy_i     (tri_q.edg_dy),
      .reject_c (reject_c)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         rdy_q    <= 1'b1;
         vld_q    <= 1'b0;
         tri_q    <= '0;
         rec_q    <= '0;
         tile_x_q <= '0;
         tile_y_q <= '0;
         e_q      <= '0;
         row_e_q  <= '0;
         z_q      <= '0;
         row_z_q  <= '0;
      end else begin
         state_q  <= state_d;
         rdy_q    <= rdy_d;
         vld_q    <= vld_d;
         tri_q    <= tri_d;
         rec_q    <= rec_d;
         tile_x_q <= tile_x_d;
         tile_y_q <= tile_y_d;
         e_q      <= e_d;
         row_e_q  <= row_e_d;
         z_q      <= z_d;
         row_z_q  <= row_z_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      vld_d    = vld_q;
      tri_d    = tri_q;
      rec_d    = rec_q;
      tile_x_d = tile_x_q;
      tile_y_d = tile_y_q;
      e_d      = e_q;
      row_e_d  = row_e_q;
      z_d      = z_q;
      row_z_d  = row_z_q;
      advance  = 1'b0;
      last_tile = (tile_x_q == tri_q.tx_max) && (tile_y_q == tri_q.ty_max);

      case (state_q)
         ST_IDLE: begin
            if (vld_in && rdy_q) begin
               tri_d.tx_min = in_tx_min;
               tri_d.tx_max = (in_tx_max > MAX_TX) ? MAX_TX : in_tx_max;
               tri_d.ty_min = in_ty_min;
               tri_d.ty_max = (in_ty_max > MAX_TY) ? MAX_TY : in_ty_max;
               tri_d.edg    = {in_edge2, in_edge1, in_edge0};
               tri_d.edg_dx = {in_edge_dx2, in_edge_dx1, in_edge_dx0};
               tri_d.edg_dy = {in_edge_dy2, in_edge_dy1, in_edge_dy0};
               tri_d.z      = in_z;
               tri_d.dzdx   = in_dzdx;
               tri_d.dzdy   = in_dzdy;
               tri_d.color  = in_color;
               state_d      = ST_SEED;
            end
         end
         ST_SEED: begin
            if ((tri_q.tx_min > tri_q.tx_max) || (tri_q.ty_min > tri_q.ty_max)) begin
               state_d = ST_IDLE;
            end else begin
               for (int i = 0; i < NUM_EDGES; i++) begin
                  e_d[i] = tri_q.edg[i]
                         + ((sext(tri_q.edg_dx[i]) * ACC_W'(tri_q.tx_min)
                           + sext(tri_q.edg_dy[i]) * ACC_W'(tri_q.ty_min)) << LOG2_TW);
               end
               z_d      = tri_q.z
                        + ((sext(tri_q.dzdx) * ACC_W'(tri_q.tx_min)
                          + sext(tri_q.dzdy) * ACC_W'(tri_q.ty_min)) << LOG2_TW);
               row_e_d  = e_d;
               row_z_d  = z_d;
               tile_x_d = tri_q.tx_min;
               tile_y_d = tri_q.ty_min;
               state_d  = ST_TEST;
            end
         end
         ST_TEST: begin
            if (reject_c) begin
               advance = 1'b1;
               state_d = last_tile ? ST_IDLE : ST_TEST;
            end else begin
               rec_d.tile_x = tile_x_q;
               rec_d.tile_y = tile_y_q;
               rec_d.abs_x  = FX_TOTAL_BITS'(tile_x_q) << ABS_SHIFT;
               rec_d.abs_y  = FX_TOTAL_BITS'(tile_y_q) << ABS_SHIFT;
               rec_d.edg    = e_q;
               rec_d.edg_dx = tri_q.edg_dx;
               rec_d.edg_dy = tri_q.edg_dy;
               rec_d.z      = z_q;
               rec_d.dzdx   = tri_q.dzdx;
               rec_d.dzdy   = tri_q.dzdy;
               rec_d.color  = tri_q.color;
               rec_d.last   = last_tile;
               vld_d        = 1'b1;
               state_d      = ST_EMIT;
            end
         end
         ST_EMIT: begin
            if (rdy_out) begin
               vld_d   = 1'b0;
               advance = 1'b1;
               state_d = last_tile ? ST_IDLE : ST_TEST;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Step to the next tile; row wrap reloads accumulators from the row start.
      if (advance) begin
         if (tile_x_q == tri_q.tx_max) begin
            tile_x_d = tri_q.tx_min;
            tile_y_d = tile_y_q + TW'(1);
            for (int i = 0; i < NUM_EDGES; i++) begin
               row_e_d[i] = row_e_q[i] + (sext(tri_q.edg_dy[i]) << LOG2_TW);
            end
            row_z_d = row_z_q + (sext(tri_q.dzdy) << LOG2_TW);
            e_d     = row_e_d;
            z_d     = row_z_d;
         end else begin
            tile_x_d = tile_x_q + TW'(1);
            for (int i = 0; i < NUM_EDGES; i++) begin
               e_d[i] = e_q[i] + (sext(tri_q.edg_dx[i]) << LOG2_TW);
            end
            z_d = z_q + (sext(tri_q.dzdx) << LOG2_TW);
         end
      end

      rdy_d = (state_d == ST_IDLE);
   end

   assign rdy_in       = rdy_q;
   assign vld_out      = vld_q;
   assign out_tile_x   = rec_q.tile_x;
   assign out_tile_y   = rec_q.tile_y;
   assign out_abs_x    = rec_q.abs_x;
   assign out_abs_y    = rec_q.abs_y;
   assign out_edge0    = rec_q.edg[0];
   assign out_edge1    = rec_q.edg[1];
   assign out_edge2    = rec_q.edg[2];
   assign out_edge_dx0 = rec_q.edg_dx[0];
   assign out_edge_dx1 = rec_q.edg_dx[1];
   assign out_edge_dx2 = rec_q.edg_dx[2];
   assign out_edge_dy0 = rec_q.edg_dy[0];
   assign out_edge_dy1 = rec_q.edg_dy[1];
   assign out_edge_dy2 = rec_q.edg_dy[2];
   assign out_z        = rec_q.z;
   assign out_dzdx     = rec_q.dzdx;
   assign out_dzdy     = rec_q.dzdy;
   assign out_color    = rec_q.color;
   assign out_last     = rec_q.last;

endmodule

// File: doc/tile_walker.md
Name: tile_walker

Overview:
- Upstream neighbour of the per-tile pixel stage.
- Accepts one set-up triangle: tile-space bounding box, edge equations and depth plane, all evaluated at screen origin. Walks the covered tiles in raster order.
- For each tile, runs a 4-corner trivial-reject test. Tiles that survive are emitted as per-tile records with edge and depth values rebased to the tile's top-left pixel, over a valid/ready handshake.

Parameters:
- FX_TOTAL_BITS, 16, fixed-point word width; edge and z accumulators are 2*FX_TOTAL_BITS.
- FX_FRAC_BITS, 4, fractional bits of fixed-point values.
- TILE_WIDTH, 8, tile edge length in pixels; must be a power of two; LOG2_TW = log2(TILE_WIDTH).
- SCREEN_TILES_X, 40, number of tile columns.
- SCREEN_TILES_Y, 30, number of tile rows.
- TW, 6, tile index width (ceil log2 of the max tile count).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- vld_in  in  1  triangle record valid.
- rdy_in  out  1  walker can accept a triangle (high only in IDLE).
- in_tx_min, in_tx_max, in_ty_min, in_ty_max  in  TW each  inclusive tile bounding box.
- in_edge0..2  in  2*FX_TOTAL_BITS signed  edge value at pixel (0,0).
- in_edge_dx0..2, in_edge_dy0..2  in  FX_TOTAL_BITS signed  per-pixel edge increments along x and along y.
- in_z  in  2*FX_TOTAL_BITS  z at (0,0).
- in_dzdx, in_dzdy  in  FX_TOTAL_BITS signed  per-pixel z increments.
- in_color  in  4  flat colour.
- rdy_out  in  1  downstream accepts a tile.
- vld_out  out  1  tile record valid.
- out_tile_x, out_tile_y  out  TW  tile index.
- out_abs_x, out_abs_y  out  FX_TOTAL_BITS  tile origin in fixed point: tile index << (LOG2_TW+FX_FRAC_BITS).
- out_edge0..2  out  2*FX_TOTAL_BITS  edge values at the tile origin.
- out_edge_dx0..2, out_edge_dy0..2, out_dzdx, out_dzdy, out_color  out  pass-through of the latched triangle fields.
- out_z  out  2*FX_TOTAL_BITS  z at the tile origin.
- out_last  out  1  last emitted tile of this triangle.

Behaviour:
- Reset: state IDLE, rdy_in=1, vld_out=0, all out_* = 0, all accumulators = 0. Reset mid-walk abandons the triangle; vld_out is low the cycle after reset asserts.
- States: IDLE, SEED, TEST, EMIT.
- IDLE:
  - On vld_in&&rdy_in, latch all inputs.
  - Clamp tx_max to SCREEN_TILES_X-1 and ty_max to SCREEN_TILES_Y-1.
  - Go to SEED. rdy_in drops the next cycle.
- SEED: compute the start accumulators at (tx_min, ty_min):
  - E = in_edge + (tx_min*dx + ty_min*dy) << LOG2_TW.
  - z computed the same way from in_z, dzdx, dzdy.
  - Copy both to row-start registers. Go to TEST.
  - If the bbox is empty (min>max on either axis), go to IDLE with no output.
- TEST (one tile per cycle), corner values per edge i:
  - c00 = E
  - c10 = E + dx*(TILE_WIDTH-1)
  - c01 = E + dy*(TILE_WIDTH-1)
  - c11 = c10 + dy*(TILE_WIDTH-1)
  - Reject if, for any edge, all four corners are <= 0.
  - Reject: advance to the next tile. If it was the last tile, go to IDLE with no output, so out_last is never set for that triangle.
  - Accept: register the output record and set vld_out=1. out_last = 1 if this is the final bbox tile or every remaining tile will be rejected; final-bbox-tile-only detection is acceptable and is the decided behaviour. Go to EMIT.
- EMIT:
  - Hold vld_out and all out_* stable while rdy_out=0.
  - On rdy_out, drop vld_out the next cycle and advance. If the last tile was emitted go to IDLE, else go to TEST.
- Advance:
  - Within a row: tile_x+1; E += dx<<LOG2_TW; z += dzdx<<LOG2_TW.
  - At tile_x == tx_max: tile_x = tx_min, tile_y+1; row-start += dy<<LOG2_TW, and E and z load from the new row-start.
- Arithmetic:
  - Increments are sign-extended to 2*FX_TOTAL_BITS before shift or multiply.
  - All sums are two's-complement, modulo 2*FX_TOTAL_BITS, with no saturation.
- Throughput: 1 cycle per rejected tile; an accepted tile takes a minimum of 2 cycles (TEST + EMIT).
- vld_in while busy is ignored, since rdy_in=0.

Decomposition:
- Add TILE_WIDTH, LOG2_TW, SCREEN_TILES_X/Y, TW and a tile_rec_t struct for the output record to raster_defines.
- One sub-module, tile_corner_test: combinational 3-edge, 4-corner reject, taking E, dx and dy vectors and producing a reject bit.

Test Plan:
- bbox x0..1, y0..0; edge0..2=100, all dx/dy=0, rdy_out=1 -> tiles (0,0) then (1,0); out_abs_x 0 then 128; out_last=1 only on the second; rdy_in returns to 1.
- edge0=-1, dx/dy=0, bbox 2x2 -> vld_out never asserts; rdy_in high again 1+1+4 cycles after accept.
- edge0=10, edge_dx0=3, others 1000, bbox x0..1 -> tile(1,0) out_edge0=34; in_z=0, dzdx=2 -> out_z=16.
- bbox x0..1, y0..1, edge_dy0=2, edge0=100 -> tile(0,1) out_edge0=116, order (0,0),(1,0),(0,1),(1,1).
- rdy_out low 5 cycles during EMIT -> vld_out and out_* stable all 5 cycles; single transfer on release.
- rst_n low during EMIT -> next cycle vld_out=0, rdy_in=1; a new triangle then walks from its own tx_min/ty_min.
